// File: rtl/ddr_definitions.sv
// Shared definitions for the DDR game blocks: arrow codes, game states,
// score limits and the arrow-to-button decode used by display and judge alike.
package ddr_definitions;

    localparam int NUM_ARROWS_BITS = 4;
    localparam int STATE_BITS      = 1;
    localparam int SCORE_BITS      = 14;
    localparam int SCORE_MAX       = 9999;

    typedef enum logic [NUM_ARROWS_BITS:0] {
        ARROW_UP    = 5'd10,
        ARROW_DOWN  = 5'd11,
        ARROW_LEFT  = 5'd12,
        ARROW_RIGHT = 5'd13,
        ARROW_UD    = 5'd14,
        ARROW_UL    = 5'd15,
        ARROW_UR    = 5'd16,
        ARROW_DL    = 5'd17,
        ARROW_DR    = 5'd18,
        ARROW_LR    = 5'd19,
        ARROW_NONE  = 5'd20
    } arrow_t;

    typedef enum logic [STATE_BITS:0] {
        STATE_START = 2'd0,
        STATE_GAME  = 2'd1,
        STATE_PAUSE = 2'd2,
        STATE_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        VERDICT_NONE,
        VERDICT_HIT,
        VERDICT_MISS
    } verdict_t;

    // Button mask order is {up, down, left, right}.
    function automatic logic [3:0] arrow_mask(input logic [NUM_ARROWS_BITS:0] code);
        case (code)
            ARROW_UP:    return 4'b1000;
            ARROW_DOWN:  return 4'b0100;
            ARROW_LEFT:  return 4'b0010;
            ARROW_RIGHT: return 4'b0001;
            ARROW_UD:    return 4'b1100;
            ARROW_UL:    return 4'b1010;
            ARROW_UR:    return 4'b1001;
            ARROW_DL:    return 4'b0110;
            ARROW_DR:    return 4'b0101;
            ARROW_LR:    return 4'b0011;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic [SCORE_BITS-1:0] sat_add(input logic [SCORE_BITS-1:0] a,
                                                      input logic [1:0]            inc,
                                                      input logic [SCORE_BITS-1:0] limit);
        logic [SCORE_BITS:0] sum;
        sum = {1'b0, a} + {{(SCORE_BITS - 1){1'b0}}, inc};
        if (sum > {1'b0, limit})
            return limit;
        return sum[SCORE_BITS-1:0];
    endfunction

endpackage

// File: rtl/ddr_judge_if.sv
// Signal bundle between the judge and the game (buttons, metronome, display).
interface ddr_judge_if #(
    parameter int NUM_ARROWS_BITS = 4,
    parameter int STATE_BITS      = 1
);
    logic                                  metronome_clk;
    logic [STATE_BITS:0]                   state;
    logic                                  new_game;
    logic [NUM_ARROWS_BITS:0]              cur_arrow;
    logic                                  btn_up;
    logic                                  btn_down;
    logic                                  btn_left;
    logic                                  btn_right;
    logic [ddr_definitions::SCORE_BITS-1:0] score;
    logic [ddr_definitions::SCORE_BITS-1:0] comboCount;
    logic [ddr_definitions::SCORE_BITS-1:0] max_combo;
    logic                                  hit;
    logic                                  miss;

    modport master (
        output metronome_clk, state, new_game, cur_arrow,
               btn_up, btn_down, btn_left, btn_right,
        input  score, comboCount, max_combo, hit, miss
    );

    modport slave (
        input  metronome_clk, state, new_game, cur_arrow,
               btn_up, btn_down, btn_left, btn_right,
        output score, comboCount, max_combo, hit, miss
    );
endinterface

// File: rtl/ddr_button_conditioner.sv
// One push button: 2-flop synchronizer, debounce counter, rising-edge press pulse.
module ddr_button_conditioner #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    logic                     sync_1;
    logic                     sync_2;
    logic                     level;
    logic                     level_d;
    logic [DEBOUNCE_BITS-1:0] count;

    // The counter measures how long the synced input has disagreed with the
    // accepted level; any return to agreement restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_d <= level;
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == '1) begin
                level <= sync_2;
                count <= '0;
            end else begin
                count <= count + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign press = level & ~level_d;
endmodule

// File: rtl/ddr_judge.sv
// Judges each metronome beat against the current arrow and keeps score,
// combo and best combo for the display.
module ddr_judge
    import ddr_definitions::*;
#(
    parameter int NUM_ARROWS_BITS    = ddr_definitions::NUM_ARROWS_BITS,
    parameter int STATE_BITS         = ddr_definitions::STATE_BITS,
    parameter int DEBOUNCE_BITS      = 16,
    parameter int COMBO_BONUS_THRESH = 10,
    parameter int SCORE_MAX          = ddr_definitions::SCORE_MAX
) (
    input logic         clk,
    input logic         rst,
    ddr_judge_if.slave  bus
);
    localparam logic [SCORE_BITS-1:0] LIMIT  = SCORE_BITS'(SCORE_MAX);
    localparam logic [SCORE_BITS-1:0] THRESH = SCORE_BITS'(COMBO_BONUS_THRESH);

    logic [NUM_ARROWS_BITS:0] arrow;
    logic [STATE_BITS:0]      game_state;
    logic [2:0]               beat_sh;
    logic                     beat;
    logic [3:0]               press;
    logic [3:0]               press_mask;
    logic [3:0]               effective;
    logic [3:0]               expected;
    logic                     in_game;
    verdict_t                 verdict;
    logic [1:0]               bonus;
    logic [SCORE_BITS-1:0]    score_q;
    logic [SCORE_BITS-1:0]    combo_q;
    logic [SCORE_BITS-1:0]    max_combo_q;
    logic [SCORE_BITS-1:0]    score_hit;
    logic [SCORE_BITS-1:0]    combo_hit;
    logic                     hit_q;
    logic                     miss_q;

    assign arrow      = bus.cur_arrow;
    assign game_state = bus.state;
    assign in_game    = (game_state == STATE_GAME);

    // Same beat detector as the display, so the judged arrow is the pre-shift one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_sh <= '0;
            beat    <= 1'b0;
        end else begin
            beat_sh <= {bus.metronome_clk, beat_sh[2:1]};
            beat    <= ~beat_sh[0] & beat_sh[1];
        end
    end

    ddr_button_conditioner #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_cond_up (
        .clk(clk), .rst(rst), .btn(bus.btn_up), .press(press[3])
    );
    ddr_button_conditioner #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_cond_down (
        .clk(clk), .rst(rst), .btn(bus.btn_down), .press(press[2])
    );
    ddr_button_conditioner #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_cond_left (
        .clk(clk), .rst(rst), .btn(bus.btn_left), .press(press[1])
    );
    ddr_button_conditioner #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_cond_right (
        .clk(clk), .rst(rst), .btn(bus.btn_right), .press(press[0])
    );

    assign expected  = arrow_mask(arrow);
    assign effective = press_mask | press;

    always_comb begin
        verdict = VERDICT_NONE;
        if (in_game && beat) begin
            if (expected != 4'b0000)
                verdict = (effective == expected) ? VERDICT_HIT : VERDICT_MISS;
            else if (effective != 4'b0000)
                verdict = VERDICT_MISS;
        end
    end

    always_comb begin
        bonus     = (combo_q >= THRESH) ? 2'd2 : 2'd1;
        score_hit = sat_add(score_q, bonus, LIMIT);
        combo_hit = sat_add(combo_q, 2'd1, LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            press_mask  <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else if (bus.new_game) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            press_mask  <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            hit_q  <= (verdict == VERDICT_HIT);
            miss_q <= (verdict == VERDICT_MISS);
            if (!in_game || beat)
                press_mask <= '0;
            else
                press_mask <= press_mask | press;
            case (verdict)
                VERDICT_HIT: begin
                    score_q <= score_hit;
                    combo_q <= combo_hit;
                    if (combo_hit > max_combo_q)
                        max_combo_q <= combo_hit;
                end
                VERDICT_MISS: combo_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.score      = score_q;
    assign bus.comboCount = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
endmodule

// File: tb/tb_ddr_judge.sv
// Directed bench for ddr_judge with a short debounce (DEBOUNCE_BITS=2).
module tb_ddr_judge;
    import ddr_definitions::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_hits;

    ddr_judge_if bus ();

    ddr_judge #(.DEBOUNCE_BITS(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int s, input int c, input int m);
        check_eq({tag, "_score"}, 32'(bus.score), s);
        check_eq({tag, "_combo"}, 32'(bus.comboCount), c);
        check_eq({tag, "_max"}, 32'(bus.max_combo), m);
    endtask

    task automatic set_btns(input logic [3:0] m);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = m;
    endtask

    // One beat: buttons go down at n0, metronome rises at n4, judge edge falls
    // between n7 and n8; hold>0 releases the buttons early at that negedge.
    task automatic play(input string tag, input logic [4:0] arrow, input logic [3:0] btns,
                        input int hold, input bit ng, input bit exp_hit, input bit exp_miss);
        @(negedge clk);
        bus.cur_arrow     = arrow;
        set_btns(btns);
        bus.metronome_clk = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == hold) set_btns(4'b0000);
            if (k == 4) bus.metronome_clk = 1'b1;
            if (k == 7 && ng) bus.new_game = 1'b1;
        end
        check_eq({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
        check_eq({tag, "_miss"}, 32'(bus.miss), 32'(exp_miss));
        bus.new_game = 1'b0;
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 32'({bus.hit, bus.miss}), 32'd0);
        set_btns(4'b0000);
        bus.metronome_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        n_hits            = 0;
        rst               = 1'b1;
        bus.metronome_clk = 1'b0;
        bus.state         = STATE_GAME;
        bus.new_game      = 1'b0;
        bus.cur_arrow     = ARROW_NONE;
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        check_stats("reset", 0, 0, 0);
        check_eq("reset_pulses", 32'({bus.hit, bus.miss}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        play("up_hit", ARROW_UP, 4'b1000, 0, 1'b0, 1'b1, 1'b0);
        check_stats("up_hit", 1, 1, 1);
        play("dl_hit", ARROW_DL, 4'b0110, 0, 1'b0, 1'b1, 1'b0);
        check_stats("dl_hit", 2, 2, 2);
        play("dl_partial", ARROW_DL, 4'b0100, 0, 1'b0, 1'b0, 1'b1);
        check_stats("dl_partial", 2, 0, 2);
        play("none_idle", ARROW_NONE, 4'b0000, 0, 1'b0, 1'b0, 1'b0);
        check_stats("none_idle", 2, 0, 2);
        play("none_press", ARROW_NONE, 4'b0001, 0, 1'b0, 1'b0, 1'b1);
        check_stats("none_press", 2, 0, 2);
        play("glitch3", ARROW_UP, 4'b1000, 3, 1'b0, 1'b0, 1'b1);
        check_stats("glitch3", 2, 0, 2);
        play("hold4", ARROW_UP, 4'b1000, 4, 1'b0, 1'b1, 1'b0);
        check_stats("hold4", 3, 1, 2);
        play("down_hit", ARROW_DOWN, 4'b0100, 0, 1'b0, 1'b1, 1'b0);
        check_stats("down_hit", 4, 2, 2);

        for (int i = 0; i < 8; i++)
            play("build", ARROW_LR, 4'b0011, 0, 1'b0, 1'b1, 1'b0);
        check_stats("build", 12, 10, 10);
        play("bonus", ARROW_UR, 4'b1001, 0, 1'b0, 1'b1, 1'b0);
        check_stats("bonus", 14, 11, 11);

        bus.state = STATE_PAUSE;
        play("pause", ARROW_UP, 4'b1000, 0, 1'b0, 1'b0, 1'b0);
        check_stats("pause", 14, 11, 11);
        bus.state = STATE_GAME;
        play("resume_empty", ARROW_UP, 4'b0000, 0, 1'b0, 1'b0, 1'b1);
        check_stats("resume_empty", 14, 0, 11);

        // Alternate up/down so each button has a full cycle to release.
        for (int i = 0; i < 4997; i++) begin
            @(negedge clk);
            bus.cur_arrow     = (i % 2 == 0) ? ARROW_UP : ARROW_DOWN;
            bus.btn_up        = (i % 2 == 0);
            bus.btn_down      = (i % 2 != 0);
            bus.metronome_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.metronome_clk = 1'b1;
            repeat (4) @(negedge clk);
            if (bus.hit) n_hits++;
        end
        check_eq("fast_hits", 32'(n_hits), 32'd4997);
        check_stats("fast", 9998, 4997, 4997);
        set_btns(4'b0000);
        bus.metronome_clk = 1'b0;
        repeat (8) @(negedge clk);
        play("sat_bonus", ARROW_RIGHT, 4'b0001, 0, 1'b0, 1'b1, 1'b0);
        check_stats("sat_bonus", 9999, 4998, 4998);
        play("sat_hold", ARROW_LEFT, 4'b0010, 0, 1'b0, 1'b1, 1'b0);
        check_stats("sat_hold", 9999, 4999, 4999);

        @(negedge clk);
        bus.cur_arrow     = ARROW_UP;
        bus.btn_up        = 1'b1;
        bus.metronome_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.metronome_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set_btns(4'b0000);
        bus.metronome_clk = 1'b0;
        #1;
        check_stats("rst_mid", 0, 0, 0);
        check_eq("rst_mid_pulses", 32'({bus.hit, bus.miss}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        play("post_rst", ARROW_UP, 4'b0000, 0, 1'b0, 1'b0, 1'b1);
        check_stats("post_rst", 0, 0, 0);

        play("pre_ng", ARROW_UP, 4'b1000, 0, 1'b0, 1'b1, 1'b0);
        check_stats("pre_ng", 1, 1, 1);
        play("new_game", ARROW_UP, 4'b1000, 0, 1'b1, 1'b0, 1'b0);
        check_stats("new_game", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
